mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction/data) arbiter onto one fixed-latency memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin conflicts; default favours data.
module mem_port_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_readM,
    input  logic                 i_writeM,
    input  logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_wdata,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    inout  wire  [WORD_SIZE-1:0] m_data,
    output logic [WORD_SIZE-1:0] num_conflict
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t               state;
    logic [3:0]           cnt;
    logic                 own_d;
    logic                 op_wr;
    logic [WORD_SIZE-1:0] wdata_q;

    logic                 i_req;
    logic                 d_req;
    logic                 both;
    logic                 grant_d;
    logic                 g_wr;
    logic [WORD_SIZE-1:0] g_addr;
    logic [WORD_SIZE-1:0] g_wdata;

    assign i_req = i_readM | i_writeM;
    assign d_req = d_readM | d_writeM;
    assign both  = i_req & d_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_d;

    assign grant_d = d_req & (~i_req | rr_d);
`else
    assign grant_d = d_req;
`endif

    // readM together with writeM is a write
    assign g_wr    = grant_d ? d_writeM  : i_writeM;
    assign g_addr  = grant_d ? d_address : i_address;
    assign g_wdata = grant_d ? d_wdata   : i_wdata;

    assign m_data = m_writeM ? wdata_q : {WORD_SIZE{1'bz}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            own_d        <= 1'b0;
            op_wr        <= 1'b0;
            wdata_q      <= '0;
            m_readM      <= 1'b0;
            m_writeM     <= 1'b0;
            m_address    <= '0;
            i_ready      <= 1'b0;
            d_ready      <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            num_conflict <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_d         <= 1'b1;
`endif
        end else begin
            if (both && num_conflict != '1)
                num_conflict <= num_conflict + 1'b1;

            unique case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state     <= ACCESS;
                        own_d     <= grant_d;
                        op_wr     <= g_wr;
                        wdata_q   <= g_wdata;
                        m_address <= g_addr;
                        m_readM   <= ~g_wr;
                        m_writeM  <= g_wr;
                        cnt       <= LAT;
`ifdef ARB_ROUND_ROBIN_EN
                        if (both)
                            rr_d <= ~grant_d;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        cnt       <= '0;
                        m_readM   <= 1'b0;
                        m_writeM  <= 1'b0;
                        m_address <= '0;
                        if (own_d)
                            d_ready <= 1'b1;
                        else
                            i_ready <= 1'b1;
                        if (!op_wr) begin
                            if (own_d)
                                d_rdata <= m_data;
                            else
                                i_rdata <= m_data;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN when compiled with it.
module tb_mem_port_arbiter;

    localparam int W = 16;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_readM, i_writeM, d_readM, d_writeM;
    logic [W-1:0] i_address, i_wdata, d_address, d_wdata;
    logic [W-1:0] i_rdata, d_rdata, m_address, num_conflict;
    logic         i_ready, d_ready, m_readM, m_writeM;
    wire  [W-1:0] m_data;

    logic         one = 1'b1;
    logic         zero = 1'b0;
    logic [3:0]   s_zero = '0;
    logic [3:0]   s_irdata, s_drdata, s_maddr, s_num;
    logic         s_irdy, s_drdy, s_mrd, s_mwr;
    wire  [3:0]   s_mdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_readM(i_readM), .i_writeM(i_writeM),
        .i_address(i_address), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_readM(d_readM), .d_writeM(d_writeM),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_readM(m_readM), .m_writeM(m_writeM),
        .m_address(m_address), .m_data(m_data),
        .num_conflict(num_conflict)
    );

    // narrow instance with both ports always requesting: counter saturation
    mem_port_arbiter #(.WORD_SIZE(4), .MEM_LATENCY(1)) sat (
        .clk(clk), .reset_n(reset_n),
        .i_readM(one), .i_writeM(zero),
        .i_address(s_zero), .i_wdata(s_zero),
        .i_rdata(s_irdata), .i_ready(s_irdy),
        .d_readM(one), .d_writeM(zero),
        .d_address(s_zero), .d_wdata(s_zero),
        .d_rdata(s_drdata), .d_ready(s_drdy),
        .m_readM(s_mrd), .m_writeM(s_mwr),
        .m_address(s_maddr), .m_data(s_mdata),
        .num_conflict(s_num)
    );

    assign s_mdata = s_mrd ? 4'h5 : 4'bzzzz;

    logic [W-1:0] mem     [256];
    logic [W-1:0] ref_mem [256];

    assign m_data = m_readM ? mem[m_address[7:0]] : {W{1'bz}};

    int           n_vec = 0;
    int           n_err = 0;
    int           c = 0;
    int           free_at, g;
    bit           act, own, op_wr, fav_i;
    logic [W-1:0] t_addr, t_wd, rd_val, exp_conf;
    logic [W-1:0] exp_rd [2];
    bit           out_q [2];
    bit           seen [2];
    logic         rd [2];
    logic         wr [2];
    logic [W-1:0] ad [2];
    logic [W-1:0] wd [2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, c);
        end
    endtask

    task automatic drive_pins();
        i_readM   = rd[0];
        i_writeM  = wr[0];
        i_address = ad[0];
        i_wdata   = wd[0];
        d_readM   = rd[1];
        d_writeM  = wr[1];
        d_address = ad[1];
        d_wdata   = wd[1];
    endtask

    task automatic clear_ports();
        for (int p = 0; p < 2; p++) begin
            out_q[p] = 1'b0;
            seen[p]  = 1'b0;
            rd[p]    = 1'b0;
            wr[p]    = 1'b0;
            ad[p]    = '0;
            wd[p]    = '0;
        end
        drive_pins();
    endtask

    task automatic model_reset();
        free_at  = c;
        act      = 1'b0;
        fav_i    = 1'b0;
        exp_conf = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        clear_ports();
    endtask

    task automatic issue(input int p, input bit w, input logic [W-1:0] a,
                         input logic [W-1:0] d);
        out_q[p] = 1'b1;
        wr[p]    = w;
        rd[p]    = w ? 1'($urandom_range(0, 1)) : 1'b1;
        ad[p]    = a;
        wd[p]    = d;
    endtask

    task automatic run(input int n, input int p_new);
        bit in_acc, rdy, ir, dr, win_d;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (m_writeM)
                mem[m_address[7:0]] = m_data;
            in_acc = act && c >= g + 1 && c <= g + L;
            rdy    = act && c == g + L + 1;
            if (rdy && !op_wr)
                exp_rd[own] = rd_val;

            check("m_readM", 32'(m_readM), 32'(in_acc && !op_wr));
            check("m_writeM", 32'(m_writeM), 32'(in_acc && op_wr));
            if (in_acc)
                check("m_address", 32'(m_address), 32'(t_addr));
            else if (!rdy)
                check("m_address_idle", 32'(m_address), 32'd0);
            if (in_acc && op_wr)
                check("m_data", 32'(m_data), 32'(t_wd));
            check("i_ready", 32'(i_ready), 32'(rdy && !own));
            check("d_ready", 32'(d_ready), 32'(rdy && own));
            check("i_rdata", 32'(i_rdata), 32'(exp_rd[0]));
            check("d_rdata", 32'(d_rdata), 32'(exp_rd[1]));
            check("num_conflict", 32'(num_conflict), 32'(exp_conf));

            // requesters: hold through the ready cycle, then release
            for (int p = 0; p < 2; p++) begin
                if (seen[p]) begin
                    seen[p]  = 1'b0;
                    out_q[p] = 1'b0;
                    rd[p]    = 1'b0;
                    wr[p]    = 1'b0;
                end
            end
            if (rdy) begin
                seen[own] = 1'b1;
                act       = 1'b0;
            end
            if (in_acc && $urandom_range(0, 7) == 0) begin
                rd[own] = 1'b0;
                wr[own] = 1'b0;
            end
            for (int p = 0; p < 2; p++)
                if (!out_q[p] && p_new > 0 && int'($urandom_range(0, 99)) < p_new)
                    issue(p, 1'($urandom_range(0, 1)),
                          W'($urandom_range(0, 63)), W'($urandom));
            drive_pins();

            ir = rd[0] | wr[0];
            dr = rd[1] | wr[1];
            if (ir && dr && exp_conf != '1)
                exp_conf = exp_conf + 16'd1;
            if (c >= free_at && (ir || dr)) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (ir && dr) begin
                    win_d = !fav_i;
                    fav_i = win_d;
                end else begin
                    win_d = dr;
                end
`else
                win_d = dr;
`endif
                own     = win_d;
                op_wr   = wr[own];
                t_addr  = ad[own];
                t_wd    = wd[own];
                act     = 1'b1;
                g       = c;
                free_at = c + L + 2;
                if (op_wr)
                    ref_mem[t_addr[7:0]] = t_wd;
                else
                    rd_val = ref_mem[t_addr[7:0]];
            end
            @(posedge clk);
            c++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = W'(i * 7 + 3);
            ref_mem[i] = W'(i * 7 + 3);
        end
        mem[8'h40]     = 16'hBEEF;
        ref_mem[8'h40] = 16'hBEEF;
        clear_ports();
        #12;
        check("rst_m_readM", 32'(m_readM), 32'd0);
        check("rst_m_writeM", 32'(m_writeM), 32'd0);
        check("rst_m_address", 32'(m_address), 32'd0);
        check("rst_ready", 32'({i_ready, d_ready}), 32'd0);
        check("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
        check("rst_num_conflict", 32'(num_conflict), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);

        issue(0, 1'b0, 16'h0040, 16'h0000);
        run(6, 0);
        check("req24_i_rdata", 32'(i_rdata), 32'h0000BEEF);
        issue(1, 1'b1, 16'h0010, 16'h1234);
        run(6, 0);
        issue(0, 1'b0, 16'h0040, 16'h0000);
        issue(1, 1'b0, 16'h0010, 16'h0000);
        run(10, 0);
        check("req26_d_rdata", 32'(d_rdata), 32'h00001234);
        for (int k = 0; k < 3; k++) begin
            issue(0, 1'b0, W'($urandom_range(0, 63)), '0);
            issue(1, 1'b0, W'($urandom_range(0, 63)), '0);
            run(10, 0);
        end
        run(3000, 30);
        run(12, 0);

        // abort a read with an asynchronous reset mid-access
        @(negedge clk);
        i_readM   = 1'b1;
        i_address = 16'h0040;
        @(posedge clk);
        #2;
        check("abort_pre_m_readM", 32'(m_readM), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_m_readM", 32'(m_readM), 32'd0);
        check("abort_m_address", 32'(m_address), 32'd0);
        check("abort_i_rdata", 32'(i_rdata), 32'd0);
        check("abort_num_conflict", 32'(num_conflict), 32'd0);
        i_readM = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_i_ready", 32'(i_ready), 32'd0);
        end
        model_reset();
        reset_n = 1'b1;
        @(posedge clk);
        issue(0, 1'b0, 16'h0040, 16'h0000);
        run(8, 0);
        run(500, 30);
        run(12, 0);
        check("sat_num_conflict", 32'(s_num), 32'h0000000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
